text_buf_ctrl: RTL and testbench

//  Parametrised text-mode character buffer: dual-port cell RAM plus control. One CPU

---
 rtl/text_buf_pkg.sv | 27 ++
 rtl/text_buf_if.sv | 37 +++
 rtl/text_buf_ram.sv | 41 ++++
 rtl/text_buf_ctrl.sv | 162 ++++++++++++++++
 tb/tb_text_buf_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_buf_pkg.sv
// Shared types for the text-mode character buffer.
// Cell layout is {fg[11:0], bg[11:0], ch[7:0]}.
package text_buf_pkg;

    localparam int unsigned CELL_W = 32;

    typedef struct packed {
        logic [11:0] fg;
        logic [11:0] bg;
        logic [7:0]  ch;
    } cell_t;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } clr_state_t;

    // Cursor highlight: swap foreground and background colours.
    function automatic cell_t swap_colours(cell_t c);
        cell_t r;
        r.fg = c.bg;
        r.bg = c.fg;
        r.ch = c.ch;
        return r;
    endfunction

endpackage

// File: rtl/text_buf_if.sv
// Bus bundle between the MMIO decoder / VGA renderer (master) and the buffer (slave).
interface text_buf_if
    import text_buf_pkg::*;
#(
    parameter int unsigned ROW_W = 5,
    parameter int unsigned COL_W = 7
);
    logic [ROW_W+COL_W-1:0] cpu_addr;
    logic                   cpu_we;
    logic                   cpu_re;
    logic [CELL_W-1:0]      cpu_wdata;
    logic [CELL_W-1:0]      cpu_rdata;
    logic                   cpu_rvalid;
    logic                   cpu_ready;
    logic                   scroll_we;
    logic [ROW_W-1:0]       scroll_in;
    logic                   clr_req;
    logic [CELL_W-1:0]      fill_word;
    logic                   busy;
    logic                   vga_re;
    logic [ROW_W-1:0]       vga_row;
    logic [COL_W-1:0]       vga_col;
    logic [CELL_W-1:0]      vga_data;
    logic                   vga_valid;

    modport master (
        output cpu_addr, cpu_we, cpu_re, cpu_wdata, scroll_we, scroll_in, clr_req, fill_word,
               vga_re, vga_row, vga_col,
        input  cpu_rdata, cpu_rvalid, cpu_ready, busy, vga_data, vga_valid
    );

    modport slave (
        input  cpu_addr, cpu_we, cpu_re, cpu_wdata, scroll_we, scroll_in, clr_req, fill_word,
               vga_re, vga_row, vga_col,
        output cpu_rdata, cpu_rvalid, cpu_ready, busy, vga_data, vga_valid
    );
endinterface

// File: rtl/text_buf_ram.sv
// True dual-port cell RAM, read-first, one-cycle registered read on both ports.
// Only port A writes; the array itself is not reset, only the read registers are.
module text_buf_ram #(
    parameter int unsigned AddrW = 12,
    parameter int unsigned DataW = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             a_en_i,
    input  logic             a_we_i,
    input  logic [AddrW-1:0] a_addr_i,
    input  logic [DataW-1:0] a_wdata_i,
    output logic [DataW-1:0] a_rdata_o,
    input  logic             b_en_i,
    input  logic [AddrW-1:0] b_addr_i,
    output logic [DataW-1:0] b_rdata_o
);
    localparam int unsigned Depth = 1 << AddrW;

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] a_rdata_q, b_rdata_q;

    // Port A write into the array
    always_ff @(posedge clk_i) begin
        if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    end

    // Read registers sample the array before this edge's write lands (read-first)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_en_i) a_rdata_q <= mem_q[a_addr_i];
            if (b_en_i) b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;
endmodule

// File: rtl/text_buf_ctrl.sv
// Text-mode character buffer: CPU port, VGA port, hardware scroll and clear engine.
// Optional feature macro TEXT_BUF_CURSOR_EN adds a blinking inverse-colour cursor.
module text_buf_ctrl
    import text_buf_pkg::*;
#(
    parameter int unsigned ROW_W     = 5,
    parameter int unsigned COL_W     = 7,
    parameter int unsigned BLINK_DIV = 25
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef TEXT_BUF_CURSOR_EN
    input  logic [ROW_W-1:0] cur_row,
    input  logic [COL_W-1:0] cur_col,
`endif
    text_buf_if.slave        bus
);
    localparam int unsigned AddrW = ROW_W + COL_W;

    clr_state_t        state_q, state_d;
    logic [AddrW-1:0]  ptr_q, ptr_d;
    logic [CELL_W-1:0] fill_q, fill_d;
    logic [ROW_W-1:0]  scroll_q;
    logic              cpu_rvalid_q, vga_valid_q;
    logic              idle;
    logic [ROW_W-1:0]  cpu_prow, vga_prow;
    logic              a_en, a_we;
    logic [AddrW-1:0]  a_addr, b_addr;
    logic [CELL_W-1:0] a_wdata, a_rdata, b_rdata;

    assign idle     = (state_q == StIdle);
    // Row addition wraps naturally at ROW_W bits
    assign cpu_prow = bus.cpu_addr[AddrW-1:COL_W] + scroll_q;
    assign vga_prow = bus.vga_row + scroll_q;
    assign b_addr   = {vga_prow, bus.vga_col};

    // Scroll offset register; loads are accepted in any FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             scroll_q <= '0;
        else if (bus.scroll_we) scroll_q <= bus.scroll_in;
    end

    // Clear engine state, pointer and latched fill value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
        end
    end

    // Clear engine next-state: one physical cell per cycle, wraps back to idle at all-ones
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fill_d  = fill_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                    fill_d  = bus.fill_word;
                end
            end
            StClear: begin
                ptr_d = ptr_q + 1'b1;
                if (&ptr_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Port A mux: clear engine owns it while active, CPU otherwise; write wins over read
    always_comb begin
        a_en    = 1'b0;
        a_we    = 1'b0;
        a_addr  = {cpu_prow, bus.cpu_addr[COL_W-1:0]};
        a_wdata = bus.cpu_wdata;
        if (!idle) begin
            a_we    = 1'b1;
            a_addr  = ptr_q;
            a_wdata = fill_q;
        end else begin
            a_we = bus.cpu_we;
            a_en = bus.cpu_re & ~bus.cpu_we;
        end
    end

    // Read-valid strobes track the accepted read one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid_q <= 1'b0;
            vga_valid_q  <= 1'b0;
        end else begin
            cpu_rvalid_q <= a_en;
            vga_valid_q  <= bus.vga_re;
        end
    end

    text_buf_ram #(
        .AddrW (AddrW),
        .DataW (CELL_W)
    ) u_ram (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .a_en_i    (a_en),
        .a_we_i    (a_we),
        .a_addr_i  (a_addr),
        .a_wdata_i (a_wdata),
        .a_rdata_o (a_rdata),
        .b_en_i    (bus.vga_re),
        .b_addr_i  (b_addr),
        .b_rdata_o (b_rdata)
    );

    assign bus.cpu_rdata  = a_rdata;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_ready  = idle;
    assign bus.busy       = ~idle;
    assign bus.vga_valid  = vga_valid_q;

`ifdef TEXT_BUF_CURSOR_EN
    logic [BLINK_DIV-1:0] blink_cnt_q;
    logic                 phase_q;
    logic [ROW_W-1:0]     vga_row_q;
    logic [COL_W-1:0]     vga_col_q;

    // Blink divider: phase flips each time the counter wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
            if (&blink_cnt_q) phase_q <= ~phase_q;
        end
    end

    // Logical VGA coordinates aligned with the RAM read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_row_q <= '0;
            vga_col_q <= '0;
        end else if (bus.vga_re) begin
            vga_row_q <= bus.vga_row;
            vga_col_q <= bus.vga_col;
        end
    end

    assign bus.vga_data = (phase_q && vga_row_q == cur_row && vga_col_q == cur_col)
                        ? swap_colours(cell_t'(b_rdata)) : b_rdata;
`else
    logic unused_blink;
    assign unused_blink = ^BLINK_DIV;
    assign bus.vga_data = b_rdata;
`endif

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Self-checking bench for text_buf_ctrl: directed table, corner sequences and
// randomized traffic against a flat-array reference model.
module tb_text_buf_ctrl;

    logic clk;
    logic rst_n;

    text_buf_if #(.ROW_W(5), .COL_W(7)) bus ();

`ifdef TEXT_BUF_CURSOR_EN
    logic [4:0] cur_row;
    logic [6:0] cur_col;
`endif

    text_buf_ctrl #(
        .ROW_W (5),
        .COL_W (7)
`ifdef TEXT_BUF_CURSOR_EN
        , .BLINK_DIV (2)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n)
`ifdef TEXT_BUF_CURSOR_EN
        , .cur_row (cur_row)
        , .cur_col (cur_col)
`endif
        , .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since reset release; drives the blink-phase expectation
    int edge_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    int n_checks;
    int n_fail;
    logic [31:0] mem [4096];
    int m_scroll;

    typedef struct {
        int          wsc;
        int          wrow;
        int          wcol;
        logic [31:0] data;
        int          rsc;
        int          rrow;
        int          rcol;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [6];

    function automatic int phys(int row, int col, int sc);
        return ((row + sc) % 32) * 128 + col;
    endfunction

    function automatic logic [31:0] vga_exp(logic [31:0] raw, int row, int col);
`ifdef TEXT_BUF_CURSOR_EN
        if (((edge_cnt / 4) % 2) == 1 && row == 2 && col == 3)
            return {raw[19:8], raw[31:20], raw[7:0]};
`endif
        if (row < 0 || col < 0) return 32'h0;
        return raw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.scroll_we = 1'b0;
        bus.clr_req   = 1'b0;
        bus.vga_re    = 1'b0;
    endtask

    task automatic set_scroll(input int s);
        bus.scroll_we = 1'b1;
        bus.scroll_in = 5'(s);
        step();
        bus.scroll_we = 1'b0;
        m_scroll = s;
    endtask

    task automatic cpu_write(input int row, input int col, input logic [31:0] d);
        bus.cpu_addr  = {5'(row), 7'(col)};
        bus.cpu_wdata = d;
        bus.cpu_we    = 1'b1;
        step();
        bus.cpu_we = 1'b0;
        mem[phys(row, col, m_scroll)] = d;
    endtask

    task automatic cpu_read_check(input string name, input int row, input int col,
                                  input logic [31:0] exp);
        bus.cpu_addr = {5'(row), 7'(col)};
        bus.cpu_re   = 1'b1;
        step();
        bus.cpu_re = 1'b0;
        check({name, "_rvalid"}, {31'd0, bus.cpu_rvalid}, 32'd1);
        check({name, "_rdata"}, bus.cpu_rdata, exp);
        step();
        check({name, "_rvalid_drop"}, {31'd0, bus.cpu_rvalid}, 32'd0);
    endtask

    task automatic vga_read_check(input string name, input int row, input int col,
                                  input logic [31:0] raw);
        bus.vga_row = 5'(row);
        bus.vga_col = 7'(col);
        bus.vga_re  = 1'b1;
        step();
        bus.vga_re = 1'b0;
        check({name, "_vvalid"}, {31'd0, bus.vga_valid}, 32'd1);
        check({name, "_vdata"}, bus.vga_data, vga_exp(raw, row, col));
    endtask

    initial begin
        int busy_cnt;
        n_checks = 0;
        n_fail   = 0;
        m_scroll = 0;
`ifdef TEXT_BUF_CURSOR_EN
        cur_row = 5'd2;
        cur_col = 7'd3;
`endif
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.scroll_in = '0;
        bus.fill_word = '0;
        bus.vga_row   = '0;
        bus.vga_col   = '0;
        idle_inputs();

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check("rst_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
        check("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_vga_data", bus.vga_data, 32'h0);
        check("rst_vga_valid", {31'd0, bus.vga_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed write/read through the scroll mapping
        vecs[0] = '{0, 1, 0,   32'h0F0FF068, 0,  1, 0,   32'h0F0FF068};
        vecs[1] = '{3, 0, 5,   32'hA5A51234, 0,  3, 5,   32'hA5A51234};
        vecs[2] = '{3, 31, 5,  32'h5A5A4321, 0,  2, 5,   32'h5A5A4321};
        vecs[3] = '{7, 10, 127, 32'h12345678, 0, 17, 127, 32'h12345678};
        vecs[4] = '{0, 0, 0,   32'hCAFEF00D, 31, 1, 0,   32'hCAFEF00D};
        vecs[5] = '{5, 30, 64, 32'h00FF00AA, 9, 26, 64,  32'h00FF00AA};
        for (int i = 0; i < 6; i++) begin
            set_scroll(vecs[i].wsc);
            cpu_write(vecs[i].wrow, vecs[i].wcol, vecs[i].data);
            set_scroll(vecs[i].rsc);
            cpu_read_check($sformatf("vec%0d_cpu", i), vecs[i].rrow, vecs[i].rcol, vecs[i].exp);
            vga_read_check($sformatf("vec%0d_vga", i), vecs[i].rrow, vecs[i].rcol, vecs[i].exp);
        end
        set_scroll(0);

        // Write and read in the same cycle: write wins, no rvalid
        bus.cpu_addr  = {5'd6, 7'd6};
        bus.cpu_wdata = 32'h600D600D;
        bus.cpu_we    = 1'b1;
        bus.cpu_re    = 1'b1;
        step();
        idle_inputs();
        mem[phys(6, 6, 0)] = 32'h600D600D;
        check("we_re_no_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
        cpu_read_check("we_re_write_done", 6, 6, 32'h600D600D);

        // CPU write and VGA read of the same cell in one cycle: VGA sees the old value
        cpu_write(4, 4, 32'h01D01D00);
        bus.cpu_addr  = {5'd4, 7'd4};
        bus.cpu_wdata = 32'h0E0E0E0E;
        bus.cpu_we    = 1'b1;
        bus.vga_row   = 5'd4;
        bus.vga_col   = 7'd4;
        bus.vga_re    = 1'b1;
        step();
        idle_inputs();
        mem[phys(4, 4, 0)] = 32'h0E0E0E0E;
        check("collision_old", bus.vga_data, 32'h01D01D00);
        vga_read_check("collision_new", 4, 4, 32'h0E0E0E0E);

        // Clear screen; a CPU write in the clr_req cycle is performed then overwritten
        set_scroll(9);
        bus.fill_word = 32'h000FFF20;
        bus.clr_req   = 1'b1;
        bus.cpu_addr  = {5'd9, 7'd9};
        bus.cpu_wdata = 32'hDEADBEEF;
        bus.cpu_we    = 1'b1;
        step();
        idle_inputs();
        bus.fill_word = 32'h77777777;
        check("clr_busy", {31'd0, bus.busy}, 32'd1);
        check("clr_ready", {31'd0, bus.cpu_ready}, 32'd0);
        busy_cnt = 0;
        while (bus.busy === 1'b1 && busy_cnt < 5000) begin
            busy_cnt++;
            bus.cpu_addr  = 12'h005;
            bus.cpu_wdata = 32'hBAD0BAD0;
            bus.cpu_we    = (busy_cnt == 10);
            bus.cpu_re    = (busy_cnt == 20);
            bus.clr_req   = (busy_cnt == 30);
            step();
            if (busy_cnt == 20) check("rvalid_while_busy", {31'd0, bus.cpu_rvalid}, 32'd0);
        end
        idle_inputs();
        check("clr_cycles", 32'(busy_cnt), 32'd4096);
        check("clr_done_ready", {31'd0, bus.cpu_ready}, 32'd1);
        for (int i = 0; i < 4096; i++) mem[i] = 32'h000FFF20;
        set_scroll(0);
        cpu_read_check("busy_write_ignored", 0, 5, 32'h000FFF20);
        set_scroll(9);
        cpu_read_check("clr_overwrites_cpu", 9, 9, 32'h000FFF20);
        for (int i = 0; i < 8; i++) begin
            int r, c;
            r = int'($urandom_range(31));
            c = int'($urandom_range(127));
            vga_read_check($sformatf("clr_fill%0d", i), r, c, 32'h000FFF20);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r, c, vr, vc, pc, pv, ns;
            logic we, re, vre, swe;
            logic [31:0] wd, exp_rd, exp_vd;
            logic exp_rv;
            r   = int'($urandom_range(31));
            c   = int'($urandom_range(127));
            vr  = int'($urandom_range(31));
            vc  = int'($urandom_range(127));
            if ($urandom_range(3) == 0) begin
                vr = r;
                vc = c;
            end
            we  = ($urandom_range(2) == 0);
            re  = ($urandom_range(1) == 0);
            vre = ($urandom_range(1) == 0);
            swe = ($urandom_range(7) == 0);
            ns  = int'($urandom_range(31));
            wd  = $urandom;
            bus.cpu_addr  = {5'(r), 7'(c)};
            bus.cpu_wdata = wd;
            bus.cpu_we    = we;
            bus.cpu_re    = re;
            bus.vga_row   = 5'(vr);
            bus.vga_col   = 7'(vc);
            bus.vga_re    = vre;
            bus.scroll_we = swe;
            bus.scroll_in = 5'(ns);
            pc     = phys(r, c, m_scroll);
            pv     = phys(vr, vc, m_scroll);
            exp_rv = re && !we;
            exp_rd = mem[pc];
            exp_vd = mem[pv];
            if (we) mem[pc] = wd;
            if (swe) m_scroll = ns;
            step();
            check("rnd_rvalid", {31'd0, bus.cpu_rvalid}, {31'd0, exp_rv});
            if (exp_rv) check("rnd_rdata", bus.cpu_rdata, exp_rd);
            check("rnd_vvalid", {31'd0, bus.vga_valid}, {31'd0, vre});
            if (vre) check("rnd_vdata", bus.vga_data, vga_exp(exp_vd, vr, vc));
        end
        idle_inputs();

`ifdef TEXT_BUF_CURSOR_EN
        // Cursor cell alternates raw / swapped every four cycles
        set_scroll(0);
        cpu_write(2, 3, 32'hABC12345);
        for (int i = 0; i < 12; i++) begin
            vga_read_check($sformatf("cursor%0d", i), 2, 3, 32'hABC12345);
        end
`endif

        // Reset in the middle of a clear
        set_scroll(5);
        bus.fill_word = 32'h11112222;
        bus.clr_req   = 1'b1;
        step();
        bus.clr_req = 1'b0;
        repeat (100) step();
        check("midclr_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midclr_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("midclr_rst_ready", {31'd0, bus.cpu_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("midclr_stays_idle", {31'd0, bus.busy}, 32'd0);
        m_scroll = 0;
        mem[0] = 32'h11112222;
        vga_read_check("midclr_cell0", 0, 0, mem[0]);
        cpu_read_check("midclr_untouched", 31, 127, mem[4095]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
